// File: rtl/instr_mem_sync.sv
// instr_mem_sync: byte-addressed instruction memory with 1-cycle registered fetch, word load port and fault reporting
module instr_mem_sync #(
    parameter int          DEPTH_BYTES = 16384,
    parameter int          ADDR_WIDTH  = 32,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  stall,
    input  logic                  flush,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic [31:0]           fetch_count,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data
);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] LIMIT = AW1'(DEPTH_BYTES);
    // lane k holds byte address 4*word+k, so every aligned word is one entry per lane
    logic [7:0]            r_mem [4][WORDS] = '{default: '{default: 8'h00}};
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic                  r_fault;
    logic [1:0]            r_code;
    logic [31:0]           r_count;
    logic [AW1-1:0]        w_fetch_end;
    logic [AW1-1:0]        w_load_end;
    logic [ADDR_WIDTH-1:0] w_load_base;
    logic [WIDX-1:0]       w_fetch_idx;
    logic [WIDX-1:0]       w_load_idx;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_fault;
    logic                  w_load_ok;
    logic [31:0]           w_rd_word;
    assign w_fetch_end    = {1'b0, fetch_pc} + AW1'(3);
    assign w_fetch_idx    = fetch_pc[WIDX+1:2];
    assign w_misaligned   = |fetch_pc[1:0];
    assign w_out_of_range = w_fetch_end >= LIMIT;
    assign w_fault        = w_misaligned | w_out_of_range;
    assign w_load_base    = load_addr & ~ADDR_WIDTH'(3);
    assign w_load_end     = {1'b0, w_load_base} + AW1'(3);
    assign w_load_ok      = w_load_end < LIMIT;
    assign w_load_idx     = w_load_base[WIDX+1:2];
    assign w_rd_word      = BIG_ENDIAN
        ? {r_mem[0][w_fetch_idx], r_mem[1][w_fetch_idx], r_mem[2][w_fetch_idx], r_mem[3][w_fetch_idx]}
        : {r_mem[3][w_fetch_idx], r_mem[2][w_fetch_idx], r_mem[1][w_fetch_idx], r_mem[0][w_fetch_idx]};
    always_ff @(posedge clk) begin
        if (!rst && load_we && w_load_ok)
            for (int k = 0; k < 4; k++)
                r_mem[k][w_load_idx] <= BIG_ENDIAN ? load_data[8*(3-k) +: 8] : load_data[8*k +: 8];
    end
    // nonblocking write above keeps a same-edge fetch on the old word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= 2'b00;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= 2'b00;
        end else if (!stall) begin
            r_valid <= fetch_req;
            r_fault <= fetch_req & w_fault;
            r_code  <= !fetch_req ? 2'b00 : w_misaligned ? 2'b01 : w_out_of_range ? 2'b10 : 2'b00;
            if (fetch_req) begin
                r_pc    <= fetch_pc;
                r_instr <= w_fault ? NOP_WORD : w_rd_word;
                r_count <= r_count + 32'd1;
            end
        end
    end
    assign instruction = r_instr;
    assign instr_pc    = r_pc;
    assign instr_valid = r_valid;
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign fetch_count = r_count;
endmodule
